// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection phase controller with pedestrian walk phases.
// Counts each phase down in whole seconds as 2-digit BCD and decodes lamps and display nibbles.
module intersection_phase_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned GREEN_SEC     = 20,
    parameter int unsigned YELLOW_SEC    = 3,
    parameter int unsigned ALLRED_SEC    = 1,
    parameter int unsigned WALK_SEC      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_btn,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic [3:0] digit7,
    output logic [3:0] digit8
);

    typedef enum logic [2:0] {
        StNsG   = 3'd0,
        StNsY   = 3'd1,
        StRedA  = 3'd2,
        StEwG   = 3'd3,
        StEwY   = 3'd4,
        StRedB  = 3'd5,
        StWalkA = 3'd6,
        StWalkB = 3'd7
    } state_e;

    localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam logic [7:0] GreenBcd  = to_bcd(GREEN_SEC);
    localparam logic [7:0] YellowBcd = to_bcd(YELLOW_SEC);
    localparam logic [7:0] AllRedBcd = to_bcd(ALLRED_SEC);
    localparam logic [7:0] WalkBcd   = to_bcd(WALK_SEC);

    if (GREEN_SEC < 1 || GREEN_SEC > 99) begin : g_bad_green
        $error("GREEN_SEC must be in 1..99");
    end
    if (YELLOW_SEC < 1 || YELLOW_SEC > 99) begin : g_bad_yellow
        $error("YELLOW_SEC must be in 1..99");
    end
    if (ALLRED_SEC < 1 || ALLRED_SEC > 99) begin : g_bad_allred
        $error("ALLRED_SEC must be in 1..99");
    end
    if (WALK_SEC < 1 || WALK_SEC > 99) begin : g_bad_walk
        $error("WALK_SEC must be in 1..99");
    end
    if (TICKS_PER_SEC < 1) begin : g_bad_ticks
        $error("TICKS_PER_SEC must be at least 1");
    end

    function automatic logic [7:0] dur_bcd(input state_e s);
        case (s)
            StNsG, StEwG:     dur_bcd = GreenBcd;
            StNsY, StEwY:     dur_bcd = YellowBcd;
            StRedA, StRedB:   dur_bcd = AllRedBcd;
            default:          dur_bcd = WalkBcd;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      cd_q, cd_d;
    logic            ped_pending_q, ped_pending_d;

    logic sec_tick;
    logic in_walk;
    logic ped_req;
    logic enter_walk;

    always_comb begin
        sec_tick = (cnt_q == CntMax);
        cnt_d    = sec_tick ? '0 : cnt_q + CntW'(1);
        in_walk  = (state_q == StWalkA) || (state_q == StWalkB);
        // A press on the transition cycle itself counts toward that decision.
        ped_req  = ped_pending_q | (ped_btn & ~in_walk);

        state_d = state_q;
        cd_d    = cd_q;
        if (sec_tick) begin
            if (cd_q == 8'h01) begin
                case (state_q)
                    StNsG:   state_d = (ew_car || ped_req) ? StNsY : StNsG;
                    StNsY:   state_d = StRedA;
                    StRedA:  state_d = ped_req ? StWalkA : StEwG;
                    StWalkA: state_d = StEwG;
                    StEwG:   state_d = StEwY;
                    StEwY:   state_d = StRedB;
                    StRedB:  state_d = ped_req ? StWalkB : StNsG;
                    default: state_d = StNsG;
                endcase
                cd_d = dur_bcd(state_d);
            end else if (cd_q[3:0] == 4'd0) begin
                cd_d = {cd_q[7:4] - 4'd1, 4'd9};
            end else begin
                cd_d = {cd_q[7:4], cd_q[3:0] - 4'd1};
            end
        end

        enter_walk    = ((state_d == StWalkA) || (state_d == StWalkB)) && !in_walk;
        ped_pending_d = enter_walk ? 1'b0 : ped_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StNsG;
            cnt_q         <= '0;
            cd_q          <= GreenBcd;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cd_q          <= cd_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        ns_light = LampRed;
        ew_light = LampRed;
        walk     = 1'b0;
        case (state_q)
            StNsG:   ns_light = LampGreen;
            StNsY:   ns_light = LampYellow;
            StEwG:   ew_light = LampGreen;
            StEwY:   ew_light = LampYellow;
            StWalkA, StWalkB: walk = 1'b1;
            default: ;
        endcase
    end

    assign phase  = state_q;
    assign digit1 = cd_q[3:0];
    assign digit2 = cd_q[7:4];
    assign digit3 = 4'hF;
    assign digit4 = 4'hF;
    assign digit5 = {1'b0, state_q};
    assign digit6 = 4'hF;
    assign digit7 = ped_pending_q ? 4'hC : 4'hF;
    assign digit8 = 4'hF;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed self-checking bench for intersection_phase_ctrl with short simulation timing.
module tb_intersection_phase_ctrl;

    logic clk;
    logic reset;
    logic ew_car;
    logic ped_btn;

    logic [2:0] ns_light, ew_light, phase;
    logic       walk;
    logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;

    logic [2:0] ns_b, ew_b, phase_b;
    logic       walk_b;
    logic [3:0] d1_b, d2_b, d3_b, d4_b, d5_b, d6_b, d7_b, d8_b;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    intersection_phase_ctrl #(
        .TICKS_PER_SEC(4),
        .GREEN_SEC    (5),
        .YELLOW_SEC   (2),
        .ALLRED_SEC   (1),
        .WALK_SEC     (3)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .ew_car  (ew_car),
        .ped_btn (ped_btn),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .phase   (phase),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .digit4  (digit4),
        .digit5  (digit5),
        .digit6  (digit6),
        .digit7  (digit7),
        .digit8  (digit8)
    );

    // Second instance exercises the two-digit BCD borrow.
    intersection_phase_ctrl #(
        .TICKS_PER_SEC(2),
        .GREEN_SEC    (20),
        .YELLOW_SEC   (2),
        .ALLRED_SEC   (1),
        .WALK_SEC     (3)
    ) u_dut20 (
        .clk     (clk),
        .reset   (reset),
        .ew_car  (1'b0),
        .ped_btn (1'b0),
        .ns_light(ns_b),
        .ew_light(ew_b),
        .walk    (walk_b),
        .phase   (phase_b),
        .digit1  (d1_b),
        .digit2  (d2_b),
        .digit3  (d3_b),
        .digit4  (d4_b),
        .digit5  (d5_b),
        .digit6  (d6_b),
        .digit7  (d7_b),
        .digit8  (d8_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!(ns_light[2] | ew_light[2]) ||
                (walk && (ns_light !== 3'b100 || ew_light !== 3'b100))) begin
                errors++;
                $display("FAIL safety t=%0t ns=%b ew=%b walk=%b", $time, ns_light, ew_light, walk);
            end
            checks++;
            if (!(ns_b[2] | ew_b[2]) || (walk_b && (ns_b !== 3'b100 || ew_b !== 3'b100))) begin
                errors++;
                $display("FAIL safety20 t=%0t ns=%b ew=%b walk=%b", $time, ns_b, ew_b, walk_b);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        ew_car  = 1'b0;
        ped_btn = 1'b0;
        do_reset();
        checks++;
        if (phase !== 3'd0 || ns_light !== 3'b001 || ew_light !== 3'b100 || walk !== 1'b0) begin
            errors++;
            $display("FAIL reset_lamps got ph=%0d ns=%b ew=%b walk=%b exp ph=0 ns=001 ew=100 walk=0",
                     phase, ns_light, ew_light, walk);
        end
        checks++;
        if (digit2 !== 4'd0 || digit1 !== 4'd5 || digit7 !== 4'hF || digit5 !== 4'h0) begin
            errors++;
            $display("FAIL reset_digits got d2=%h d1=%h d7=%h d5=%h exp 0 5 F 0",
                     digit2, digit1, digit7, digit5);
        end
        checks++;
        if (digit3 !== 4'hF || digit4 !== 4'hF || digit6 !== 4'hF || digit8 !== 4'hF) begin
            errors++;
            $display("FAIL reset_blank got %h %h %h %h exp F F F F", digit3, digit4, digit6, digit8);
        end
    endtask

    task automatic test_rest();
        logic [3:0] exp_cd;
        ew_car  = 1'b0;
        ped_btn = 1'b0;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            exp_cd = 4'(5 - ((k / 4) % 5));
            checks++;
            if (phase !== 3'd0 || digit1 !== exp_cd || digit2 !== 4'd0 || digit5 !== 4'd0) begin
                errors++;
                $display("FAIL rest k=%0d got ph=%0d d2=%h d1=%h d5=%h exp ph=0 d2=0 d1=%h d5=0",
                         k, phase, digit2, digit1, digit5, exp_cd);
            end
            checks++;
            if (digit3 !== 4'hF || digit4 !== 4'hF || digit6 !== 4'hF || digit8 !== 4'hF) begin
                errors++;
                $display("FAIL rest_blank k=%0d got %h %h %h %h exp F", k, digit3, digit4, digit6,
                         digit8);
            end
            step(1);
        end
    endtask

    task automatic test_ew_sequence();
        logic [2:0] seg_ph  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        int         seg_len [6] = '{20, 8, 4, 20, 8, 4};
        int         seg_sec [6] = '{5, 2, 1, 5, 2, 1};
        logic [2:0] seg_ns  [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        logic [2:0] seg_ew  [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [3:0] exp_cd;
        ew_car  = 1'b1;
        ped_btn = 1'b0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < seg_len[s]; i++) begin
                exp_cd = 4'(seg_sec[s] - i / 4);
                checks++;
                if (phase !== seg_ph[s] || ns_light !== seg_ns[s] || ew_light !== seg_ew[s] ||
                    digit1 !== exp_cd || walk !== 1'b0) begin
                    errors++;
                    $display("FAIL ew_seq s=%0d i=%0d got ph=%0d ns=%b ew=%b d1=%h w=%b exp ph=%0d ns=%b ew=%b d1=%h w=0",
                             s, i, phase, ns_light, ew_light, digit1, walk, seg_ph[s], seg_ns[s],
                             seg_ew[s], exp_cd);
                end
                step(1);
            end
        end
        checks++;
        if (phase !== 3'd0 || digit1 !== 4'd5) begin
            errors++;
            $display("FAIL ew_seq_wrap got ph=%0d d1=%h exp ph=0 d1=5", phase, digit1);
        end
        ew_car = 1'b0;
    endtask

    task automatic test_ped_pulse();
        ew_car  = 1'b0;
        ped_btn = 1'b0;
        do_reset();
        step(2);
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        checks++;
        if (digit7 !== 4'hC) begin
            errors++;
            $display("FAIL ped_latch got d7=%h exp C", digit7);
        end
        step(17);
        checks++;
        if (phase !== 3'd1 || digit7 !== 4'hC) begin
            errors++;
            $display("FAIL ped_nsy got ph=%0d d7=%h exp ph=1 d7=C", phase, digit7);
        end
        step(8);
        checks++;
        if (phase !== 3'd2 || digit7 !== 4'hC) begin
            errors++;
            $display("FAIL ped_reda got ph=%0d d7=%h exp ph=2 d7=C", phase, digit7);
        end
        step(4);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (phase !== 3'd6 || walk !== 1'b1 || digit7 !== 4'hF || digit1 !== 4'(3 - i / 4)) begin
                errors++;
                $display("FAIL ped_walka i=%0d got ph=%0d w=%b d7=%h d1=%h exp ph=6 w=1 d7=F d1=%0d",
                         i, phase, walk, digit7, digit1, 3 - i / 4);
            end
            step(1);
        end
        checks++;
        if (phase !== 3'd3 || walk !== 1'b0 || ew_light !== 3'b001) begin
            errors++;
            $display("FAIL ped_ewg got ph=%0d w=%b ew=%b exp ph=3 w=0 ew=001", phase, walk, ew_light);
        end
    endtask

    task automatic test_ped_held();
        ew_car  = 1'b0;
        ped_btn = 1'b1;
        do_reset();
        step(1);
        checks++;
        if (digit7 !== 4'hC) begin
            errors++;
            $display("FAIL held_latch got d7=%h exp C", digit7);
        end
        step(31);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (phase !== 3'd6 || digit7 !== 4'hF || walk !== 1'b1) begin
                errors++;
                $display("FAIL held_walka i=%0d got ph=%0d d7=%h w=%b exp ph=6 d7=F w=1",
                         i, phase, digit7, walk);
            end
            step(1);
        end
        checks++;
        if (phase !== 3'd3 || digit7 !== 4'hF) begin
            errors++;
            $display("FAIL held_ewg0 got ph=%0d d7=%h exp ph=3 d7=F", phase, digit7);
        end
        step(1);
        checks++;
        if (phase !== 3'd3 || digit7 !== 4'hC) begin
            errors++;
            $display("FAIL held_ewg1 got ph=%0d d7=%h exp ph=3 d7=C", phase, digit7);
        end
        step(30);
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL held_redb got ph=%0d exp 5", phase);
        end
        step(1);
        checks++;
        if (phase !== 3'd7 || walk !== 1'b1 || digit7 !== 4'hF) begin
            errors++;
            $display("FAIL held_walkb got ph=%0d w=%b d7=%h exp ph=7 w=1 d7=F", phase, walk, digit7);
        end
        ped_btn = 1'b0;
    endtask

    task automatic test_bcd_wrap();
        int exp_v;
        ew_car  = 1'b0;
        ped_btn = 1'b0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            exp_v = 20 - k / 2;
            checks++;
            if (d2_b > 4'd9 || d1_b > 4'd9 || d2_b !== 4'(exp_v / 10) || d1_b !== 4'(exp_v % 10) ||
                phase_b !== 3'd0) begin
                errors++;
                $display("FAIL bcd k=%0d got ph=%0d d2=%h d1=%h exp ph=0 d2=%0d d1=%0d",
                         k, phase_b, d2_b, d1_b, exp_v / 10, exp_v % 10);
            end
            step(1);
        end
        checks++;
        if (d2_b !== 4'd2 || d1_b !== 4'd0) begin
            errors++;
            $display("FAIL bcd_reload got d2=%h d1=%h exp 2 0", d2_b, d1_b);
        end
    endtask

    task automatic test_reset_mid();
        ew_car  = 1'b1;
        ped_btn = 1'b0;
        do_reset();
        step(54);
        checks++;
        if (phase !== 3'd4 || ew_light !== 3'b010) begin
            errors++;
            $display("FAIL mid_ewy got ph=%0d ew=%b exp ph=4 ew=010", phase, ew_light);
        end
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        checks++;
        if (digit7 !== 4'hC) begin
            errors++;
            $display("FAIL mid_pend got d7=%h exp C", digit7);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if (phase !== 3'd0 || digit2 !== 4'd0 || digit1 !== 4'd5 || digit7 !== 4'hF ||
            ns_light !== 3'b001 || ew_light !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset got ph=%0d d2=%h d1=%h d7=%h ns=%b ew=%b exp 0 0 5 F 001 100",
                     phase, digit2, digit1, digit7, ns_light, ew_light);
        end
        reset  = 1'b0;
        ew_car = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        ew_car  = 1'b0;
        ped_btn = 1'b0;
        test_reset();
        test_rest();
        test_ew_sequence();
        test_ped_pulse();
        test_ped_held();
        test_bcd_wrap();
        test_reset_mid();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
